// File: rtl/divider_unit.sv
// divider_unit: iterative 32-bit divider for RISC-V DIV/DIVU/REM/REMU.
//
// Unsigned restoring division runs on operand magnitudes, one quotient bit
// per cycle. The signs are applied once the 32 steps are done. A request is
// accepted in IDLE and iterates in CALC. The result is then presented for
// exactly one cycle in DONE, with ready high.
//
// Optional build macro: DIV_FAST_ZERO_EN
//   When defined, a divide-by-zero request skips the 32-step loop. The
//   accepting edge preloads the final divide-by-zero datapath values, so
//   ready rises after the first edge following acceptance. The results are
//   identical with and without the macro.
`timescale 1ns/1ps

module divider_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [1:0]  DIVop,
    input  logic        valid,
    output logic [31:0] divOrRemRslt,
    output logic        ready
);

    // DIVop encoding: bit 1 selects remainder, bit 0 selects unsigned.
    //   DIV=0, DIVU=1, REM=2, REMU=3
    localparam logic [5:0] LastStep = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  op_q;        // captured DIVop
    logic [31:0] rem_q;       // partial remainder
    logic [31:0] quo_q;       // dividend shifting out / quotient shifting in
    logic [31:0] dvsr_q;      // divisor magnitude
    logic        neg_quo_q;   // raw sign difference, divisor non-zero
    logic        neg_rem_q;   // raw dividend sign
    logic [5:0]  cnt_q;       // completed steps
    logic        ready_q;
    logic [31:0] result_q;

    // Operand decode at acceptance: signedness, magnitudes, zero divisor.
    logic        op_signed;
    logic        dvd_neg;
    logic        dvs_neg;
    logic        dvs_zero;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;

    always_comb begin
        op_signed = ~DIVop[0];
        dvd_neg   = op_signed & dividend[31];
        dvs_neg   = op_signed & divisor[31];
        dvs_zero  = (divisor == 32'd0);
        // The magnitude of 0x80000000 stays 0x80000000, which is correct as an unsigned value.
        dvd_abs   = dvd_neg ? (~dividend + 32'd1) : dividend;
        dvs_abs   = dvs_neg ? (~divisor + 32'd1) : divisor;
    end

    // One restoring step: shift {rem,quo} left, then subtract if rem >= divisor.
    logic [32:0] rem_shift;
    logic [31:0] rem_diff;
    logic        step_ge;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        step_ge   = (rem_shift >= {1'b0, dvsr_q});
        // The true difference fits in 32 bits whenever step_ge is set.
        rem_diff  = rem_shift[31:0] - dvsr_q;
        rem_step  = step_ge ? rem_diff : rem_shift[31:0];
        quo_step  = {quo_q[30:0], step_ge};
    end

    // Sign fix-up of the finished magnitudes, then quotient/remainder select.
    // Divide-by-zero needs no special case here: the loop leaves quo=all ones
    // and rem=|dividend|, and the remainder sign fix restores the dividend.
    logic        apply_neg_quo;
    logic        apply_neg_rem;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_rslt;

    always_comb begin
        apply_neg_quo = ~op_q[0] & neg_quo_q;
        apply_neg_rem = ~op_q[0] & neg_rem_q;
        quo_fix       = apply_neg_quo ? (~quo_q + 32'd1) : quo_q;
        rem_fix       = apply_neg_rem ? (~rem_q + 32'd1) : rem_q;
        final_rslt    = op_q[1] ? rem_fix : quo_fix;
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            op_q      <= 2'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= 6'd0;
            ready_q   <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (valid) begin
                        op_q      <= DIVop;
                        dvsr_q    <= dvs_abs;
                        neg_quo_q <= (dividend[31] ^ divisor[31]) & ~dvs_zero;
                        neg_rem_q <= dividend[31];
`ifdef DIV_FAST_ZERO_EN
                        if (dvs_zero) begin
                            // Preload the state the loop would reach after 32 steps.
                            rem_q <= dvd_abs;
                            quo_q <= 32'hFFFF_FFFF;
                            cnt_q <= LastStep;
                        end else begin
                            rem_q <= 32'd0;
                            quo_q <= dvd_abs;
                            cnt_q <= 6'd0;
                        end
`else
                        rem_q <= 32'd0;
                        quo_q <= dvd_abs;
                        cnt_q <= 6'd0;
`endif
                        state_q <= CALC;
                    end
                end

                CALC: begin
                    ready_q <= 1'b0;
                    if (!valid) begin
                        // The controller withdrew the request. Abort without a result.
                        state_q <= IDLE;
                    end else if (cnt_q == LastStep) begin
                        result_q <= final_rslt;
                        ready_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end

                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready        = ready_q;
    assign divOrRemRslt = result_q;

endmodule
